pwm_feedback_sampler: RTL and testbench



---
 rtl/pwm_fb_pkg.sv | 17 +
 rtl/pwm_feedback_sampler_if.sv | 13 +
 rtl/spi_adc_rx.sv | 75 +++++++
 rtl/pwm_feedback_sampler.sv | 155 +++++++++++++++
 tb/tb_pwm_feedback_sampler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_fb_pkg.sv
// Shared types and constants for the PWM feedback sampler.
//   state_t        - frame sequencer states
//   ADC_FRAME_BITS - SCLK periods per conversion frame
//   ADC_LEAD_ZEROS - leading zero bits the ADC emits before the data MSB
package pwm_fb_pkg;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_LEAD_ZEROS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    QUIET  = 2'd2,
    DECIDE = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_feedback_sampler_if.sv
// Serial ADC link between the feedback sampler and the converter-output ADC.
//   adc_cs_n - chip select, active-low
//   adc_sclk - serial clock, idles high
//   adc_miso - serial data from the ADC
// master: the sampler side; slave: the ADC side.
interface pwm_feedback_sampler_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_miso;

  modport master (output adc_cs_n, output adc_sclk, input adc_miso);
  modport slave  (input adc_cs_n, input adc_sclk, output adc_miso);
endinterface

// File: rtl/spi_adc_rx.sv
// SPI receiver for one ADC conversion frame.
//   clock, reset - system clock, async active-high reset
//   start_i      - begin a frame (ignored while busy)
//   done_c       - 1-cycle strobe in the last CONV cycle (final rising tick)
//   data_o       - conversion result, complete from the cycle after done_c
//   adc          - serial link (cs_n, sclk out; miso in)
module spi_adc_rx
  import pwm_fb_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned ADC_BITS = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_i,
  output logic                   done_c,
  output logic [ADC_BITS-1:0]    data_o,
  pwm_feedback_sampler_if.master adc
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALF_N = 2 * ADC_FRAME_BITS;
  localparam int unsigned HALF_W = $clog2(HALF_N);
  localparam int unsigned DATA_W = ADC_FRAME_BITS - ADC_LEAD_ZEROS;

  logic              busy_q;
  logic              cs_n_q;
  logic              sclk_q;
  logic [DIV_W-1:0]  div_q;
  logic [HALF_W-1:0] half_q;
  logic [DATA_W-1:0] shift_q;
  logic              tick_c;

  // One tick per SCLK half-period; the final tick is the 16th rising edge.
  assign tick_c = busy_q && (div_q == DIV_W'(CLK_DIV - 1));
  assign done_c = tick_c && (half_q == HALF_W'(HALF_N - 1));

  // SCLK divider, toggle counter and MSB-first shift register; leading zeros fall off the top.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      div_q   <= '0;
      half_q  <= '0;
      shift_q <= '0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q <= 1'b1;
        cs_n_q <= 1'b0;
        sclk_q <= 1'b1;
        div_q  <= '0;
        half_q <= '0;
      end
    end else begin
      div_q <= tick_c ? '0 : div_q + DIV_W'(1);
      if (tick_c) begin
        sclk_q <= ~sclk_q;
        half_q <= half_q + HALF_W'(1);
        if (!sclk_q) begin
          shift_q <= {shift_q[DATA_W-2:0], adc.adc_miso};
        end
        if (done_c) begin
          busy_q <= 1'b0;
          cs_n_q <= 1'b1;
        end
      end
    end
  end

  assign data_o       = ADC_BITS'(shift_q);
  assign adc.adc_cs_n = cs_n_q;
  assign adc.adc_sclk = sclk_q;

endmodule

// File: rtl/pwm_feedback_sampler.sv
// Samples the converter output through a serial ADC, averages 2^AVG_LOG2
// conversions and compares against a setpoint with hysteresis to produce the
// fb level for the PWM generator, plus a sticky over-voltage fault.
//   clock, reset - system clock, async active-high reset
//   setpoint     - regulation target, sampled at decision time
//   fault_clr    - synchronous clear of fault (a simultaneous set wins)
//   fb           - 1 lowers duty, 0 raises it; forced high while fault
//   fb_valid     - 1-cycle strobe per decision
//   sample       - most recent raw conversion
//   fault        - sticky over-voltage flag
//   adc          - serial ADC link
module pwm_feedback_sampler
  import pwm_fb_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned ADC_BITS = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned HYST     = 8,
  parameter int unsigned OV_LIMIT = 4000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADC_BITS-1:0]    setpoint,
  input  logic                   fault_clr,
  output logic                   fb,
  output logic                   fb_valid,
  output logic [ADC_BITS-1:0]    sample,
  output logic                   fault,
  pwm_feedback_sampler_if.master adc
);

  localparam int unsigned ACC_W   = ADC_BITS + AVG_LOG2;
  localparam int unsigned CMP_W   = ADC_BITS + 1;
  localparam int unsigned FRM_W   = AVG_LOG2 + 1;
  localparam int unsigned AVG_N   = 2 ** AVG_LOG2;
  localparam int unsigned QUIET_N = 2 * CLK_DIV;
  localparam int unsigned QCNT_W  = $clog2(QUIET_N);

  state_t              state_q, state_d;
  logic [QCNT_W-1:0]   qcnt_q, qcnt_d;
  logic [FRM_W-1:0]    frame_q, frame_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADC_BITS-1:0] sample_q, sample_d;
  logic                fb_q, fb_d;
  logic                fb_valid_q, fb_valid_d;
  logic                fault_q, fault_d;

  logic                start_c;
  logic                rx_done_c;
  logic [ADC_BITS-1:0] rx_data;
  logic                load_c;
  logic                ov_set_c;
  logic [ADC_BITS-1:0] avg_c;
  logic [CMP_W-1:0]    hi_c;
  logic [ADC_BITS-1:0] lo_c;

  spi_adc_rx #(
    .CLK_DIV  (CLK_DIV),
    .ADC_BITS (ADC_BITS)
  ) u_rx (
    .clock   (clock),
    .reset   (reset),
    .start_i (start_c),
    .done_c  (rx_done_c),
    .data_o  (rx_data),
    .adc     (adc)
  );

  assign start_c  = (state_q == IDLE);
  // First QUIET cycle: the receiver's shift register holds the finished conversion.
  assign load_c   = (state_q == QUIET) && (qcnt_q == '0);
  assign ov_set_c = load_c && (rx_data >= ADC_BITS'(OV_LIMIT));

  // Hysteresis band; hi carries one extra bit so setpoint+HYST cannot wrap.
  assign avg_c = ADC_BITS'(acc_q >> AVG_LOG2);
  assign hi_c  = CMP_W'(setpoint) + CMP_W'(HYST);
  assign lo_c  = (setpoint >= ADC_BITS'(HYST)) ? setpoint - ADC_BITS'(HYST) : '0;

  // Frame sequencing, accumulation, decision and fault.
  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    frame_d    = frame_q;
    acc_d      = acc_q;
    sample_d   = sample_q;
    fb_d       = fb_q;
    fb_valid_d = 1'b0;
    fault_d    = fault_q;

    case (state_q)
      IDLE: state_d = CONV;
      CONV: begin
        if (rx_done_c) begin
          state_d = QUIET;
          qcnt_d  = '0;
        end
      end
      QUIET: begin
        qcnt_d = qcnt_q + QCNT_W'(1);
        if (load_c) begin
          sample_d = rx_data;
          acc_d    = acc_q + ACC_W'(rx_data);
          frame_d  = frame_q + FRM_W'(1);
        end
        if (qcnt_q == QCNT_W'(QUIET_N - 1)) begin
          state_d = (frame_q == FRM_W'(AVG_N)) ? DECIDE : IDLE;
        end
      end
      DECIDE: begin
        if (CMP_W'(avg_c) > hi_c) begin
          fb_d = 1'b1;
        end else if (avg_c < lo_c) begin
          fb_d = 1'b0;
        end
        fb_valid_d = 1'b1;
        acc_d      = '0;
        frame_d    = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fault_clr) fault_d = 1'b0;
    if (ov_set_c)  fault_d = 1'b1;
    if (fault_d)   fb_d    = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      qcnt_q     <= '0;
      frame_q    <= '0;
      acc_q      <= '0;
      sample_q   <= '0;
      fb_q       <= 1'b0;
      fb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      frame_q    <= frame_d;
      acc_q      <= acc_d;
      sample_q   <= sample_d;
      fb_q       <= fb_d;
      fb_valid_q <= fb_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign fb       = fb_q;
  assign fb_valid = fb_valid_q;
  assign sample   = sample_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_pwm_feedback_sampler.sv
// Directed bench for pwm_feedback_sampler with a behavioural serial ADC.
// Cycle k means the clock cycle after the k-th rising edge following a
// reference point; outputs are sampled on falling edges.
module tb_pwm_feedback_sampler;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] setpoint;
  logic        fault_clr;
  logic        fb;
  logic        fb_valid;
  logic [11:0] sample;
  logic        fault;

  pwm_feedback_sampler_if adc_if ();

  pwm_feedback_sampler dut (
    .clock     (clock),
    .reset     (reset),
    .setpoint  (setpoint),
    .fault_clr (fault_clr),
    .fb        (fb),
    .fb_valid  (fb_valid),
    .sample    (sample),
    .fault     (fault),
    .adc       (adc_if)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // ADC model: conversion value per frame, indexed by frame number mod 4.
  int unsigned adc_vals [4];
  int unsigned frame_idx = 0;
  int          bitpos    = 15;
  logic [15:0] word      = '0;

  // Latch a word on cs_n fall (sclk is high then); shift a bit out on each sclk fall.
  always @(negedge adc_if.adc_cs_n or negedge adc_if.adc_sclk or posedge reset) begin
    if (reset) begin
      frame_idx       = 0;
      bitpos          = 15;
      adc_if.adc_miso = 1'b0;
    end else if (!adc_if.adc_cs_n) begin
      if (adc_if.adc_sclk) begin
        word      = 16'(adc_vals[frame_idx % 4]);
        frame_idx = frame_idx + 1;
        bitpos    = 15;
      end else begin
        adc_if.adc_miso = word[bitpos];
        if (bitpos > 0) bitpos = bitpos - 1;
      end
    end
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_vals(input int unsigned a, input int unsigned b,
                          input int unsigned c, input int unsigned d);
    adc_vals[0] = a;
    adc_vals[1] = b;
    adc_vals[2] = c;
    adc_vals[3] = d;
  endtask

  // Falling edges until fb_valid is seen, bounded.
  task automatic next_valid(output int unsigned n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!fb_valid && n < 2000);
  endtask

  task automatic decide(input string tag, input int unsigned sp,
                        input int unsigned a, input int unsigned b,
                        input int unsigned c, input int unsigned d,
                        input int unsigned exp_n, input int unsigned exp_fb);
    int unsigned n;
    setpoint = 12'(sp);
    set_vals(a, b, c, d);
    next_valid(n);
    check_eq({tag, "_period"}, n, exp_n);
    check_eq({tag, "_fb"}, fb, exp_fb);
  endtask

  initial begin
    int unsigned n;
    reset     = 1'b1;
    setpoint  = 12'd2000;
    fault_clr = 1'b0;
    set_vals(2048, 2048, 2048, 2048);

    // Reset state
    step(3);
    check_eq("rst_cs_n", adc_if.adc_cs_n, 1);
    check_eq("rst_sclk", adc_if.adc_sclk, 1);
    check_eq("rst_fb", fb, 0);
    check_eq("rst_fb_valid", fb_valid, 0);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_fault", fault, 0);

    // Release; cycle 0 is IDLE, cs_n falls on the first edge
    reset = 1'b0;
    #1;
    check_eq("cs_idle", adc_if.adc_cs_n, 1);
    step(1);
    check_eq("cs_fall", adc_if.adc_cs_n, 0);
    check_eq("sclk_start", adc_if.adc_sclk, 1);
    step(3);
    check_eq("sclk_c4", adc_if.adc_sclk, 1);
    step(1);
    check_eq("sclk_first_fall", adc_if.adc_sclk, 0);
    step(124);
    check_eq("cs_quiet", adc_if.adc_cs_n, 1);
    check_eq("sample_pre", sample, 0);
    step(1);
    check_eq("sample_2048", sample, 2048);

    // First decision at cycle 549: avg 2048 > 2008
    next_valid(n);
    check_eq("d1_period", n, 419);
    check_eq("d1_fb", fb, 1);

    // avg 2000 inside band: fb holds 1
    set_vals(1995, 2005, 1998, 2002);
    step(1);
    check_eq("valid_pulse_width", fb_valid, 0);
    next_valid(n);
    check_eq("hold_mid_period", n, 548);
    check_eq("hold_mid_fb", fb, 1);
    check_eq("last_sample", sample, 2002);

    // lo saturates at 0: avg 0 is not below it, fb holds 1
    decide("lo_sat", 4, 0, 0, 0, 0, 549, 1);
    decide("low", 2000, 1900, 1900, 1900, 1900, 549, 0);
    // 8035 >> 2 = 2008 (truncated) equals hi: hold 0
    decide("trunc_hi", 2000, 2009, 2009, 2009, 2008, 549, 0);
    decide("above_hi", 2000, 2009, 2009, 2009, 2009, 549, 1);
    decide("at_lo", 2000, 1992, 1992, 1992, 1992, 549, 1);
    decide("below_lo", 2000, 1991, 1991, 1991, 1991, 549, 0);

    // Over-voltage in frame 1; QUIET entry at cycle 266, fault visible at 267
    set_vals(1000, 4095, 1000, 1000);
    step(266);
    check_eq("ov_pre_fault", fault, 0);
    check_eq("ov_pre_fb", fb, 0);
    step(1);
    check_eq("ov_fault", fault, 1);
    check_eq("ov_fb_forced", fb, 1);
    check_eq("ov_sample", sample, 4095);
    next_valid(n);
    check_eq("ov_period", n, 282);
    check_eq("ov_decide_fb", fb, 1);
    check_eq("ov_sticky", fault, 1);

    // Clear: fault drops, fb holds until the next decision releases it
    set_vals(1000, 1000, 1000, 1000);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check_eq("clr_fault", fault, 0);
    check_eq("clr_fb_hold", fb, 1);
    next_valid(n);
    check_eq("clr_period", n, 548);
    check_eq("clr_decide_fb", fb, 0);

    // Clear coinciding with a new over-voltage sample: set wins
    set_vals(1000, 4095, 1000, 1000);
    step(266);
    check_eq("sbc_pre_fault", fault, 0);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check_eq("sbc_fault", fault, 1);
    check_eq("sbc_fb", fb, 1);
    next_valid(n);
    check_eq("sbc_period", n, 282);
    check_eq("sbc_decide_fb", fb, 1);

    // Reset at cycle 60 of frame 2 aborts the frame asynchronously
    set_vals(2000, 2000, 2000, 2000);
    step(334);
    check_eq("mid_cs_low", adc_if.adc_cs_n, 0);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_cs_n", adc_if.adc_cs_n, 1);
    check_eq("mid_rst_sclk", adc_if.adc_sclk, 1);
    check_eq("mid_rst_fault", fault, 0);
    check_eq("mid_rst_fb", fb, 0);
    step(2);
    reset = 1'b0;
    // avg 2000 holds fb at 0 only if the partial accumulation was discarded
    next_valid(n);
    check_eq("post_rst_period", n, 549);
    check_eq("post_rst_fb", fb, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
